// File: rtl/inverse_factorial_if.sv
// ---------------------------------------------------------------------------
// inverse_factorial_if
// Handshake and result bundle for the inverse_factorial engine.
//   start    : level request from the controller
//   xin      : value to invert (captured once per request)
//   busy     : engine is loading or stepping
//   done     : results valid; held while start stays high
//   n_out    : largest n with n! <= value
//   fact_out : n_out!
//   exact    : value is exactly a factorial
//   err      : value was zero, no n exists
//   rem      : value - n! (present only with INVFACT_REMAINDER_EN)
// Modports: master = controller side, slave = engine side.
// ---------------------------------------------------------------------------
interface inverse_factorial_if #(
    parameter int W  = 16,
    parameter int KW = 4
);
    logic          start;
    logic [W-1:0]  xin;
    logic          busy;
    logic          done;
    logic [KW-1:0] n_out;
    logic [W-1:0]  fact_out;
    logic          exact;
    logic          err;
`ifdef INVFACT_REMAINDER_EN
    logic [W-1:0]  rem;

    modport master (
        output start, xin,
        input  busy, done, n_out, fact_out, exact, err, rem
    );
    modport slave (
        input  start, xin,
        output busy, done, n_out, fact_out, exact, err, rem
    );
`else
    modport master (
        output start, xin,
        input  busy, done, n_out, fact_out, exact, err
    );
    modport slave (
        input  start, xin,
        output busy, done, n_out, fact_out, exact, err
    );
`endif
endinterface

// File: rtl/inverse_factorial.sv
// ---------------------------------------------------------------------------
// inverse_factorial
// Finds the largest n such that n! <= value, one trial multiplication per
// cycle. Reports n, n!, whether the value is an exact factorial, and an
// error flag for a zero value. Uses a start/done level handshake.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : inverse_factorial_if.slave (start, xin in; busy, done, n_out,
//           fact_out, exact, err [, rem] out)
//
// Optional build macro: INVFACT_REMAINDER_EN adds the rem output
// (value - n!) carried on the interface.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | capture xin, seed acc=1, k=1
// STEP  | try acc*(k+1); accept while it stays <= value
// DONE  | results valid; leave when start drops
// ---------------------------------------------------------------------------
module inverse_factorial #(
    parameter int W  = 16,
    parameter int KW = 4
) (
    input  logic               clk,
    input  logic               reset,
    inverse_factorial_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_val;
    logic [W-1:0]  r_acc;
    logic [KW-1:0] r_k;

    logic [KW:0]   w_k_inc;
    logic [W+3:0]  w_next;
    logic          w_accept;
    logic          w_err;

    // Product is formed 4 bits wider than the value so an overflowing trial
    // still compares correctly as "too big" instead of wrapping.
    assign w_k_inc  = {1'b0, r_k} + {{KW{1'b0}}, 1'b1};
    assign w_next   = (W+4)'(r_acc) * (W+4)'(w_k_inc);
    assign w_accept = (w_next <= {4'b0000, r_val});
    assign w_err    = (r_val == '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = (bus.xin == '0) ? S_DONE : S_STEP;
            S_STEP: if (!w_accept) w_state_nxt = S_DONE;
            S_DONE: if (!bus.start) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_val <= '0;
            r_acc <= '0;
            r_k   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_val <= bus.xin;
                    r_acc <= {{(W-1){1'b0}}, 1'b1};
                    r_k   <= {{(KW-1){1'b0}}, 1'b1};
                end
                S_STEP: begin
                    if (w_accept) begin
                        r_acc <= w_next[W-1:0];
                        r_k   <= w_k_inc[KW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef INVFACT_REMAINDER_EN
    logic [W-1:0] w_rem;
    assign w_rem = r_val - r_acc;
`endif

    // Output decode: everything is forced to zero outside its valid state,
    // and the zero-value case suppresses the numeric results.
    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.n_out    = '0;
        bus.fact_out = '0;
        bus.exact    = 1'b0;
        bus.err      = 1'b0;
`ifdef INVFACT_REMAINDER_EN
        bus.rem      = '0;
`endif
        case (r_state)
            S_LOAD, S_STEP: bus.busy = 1'b1;
            S_DONE: begin
                bus.done = 1'b1;
                bus.err  = w_err;
                if (!w_err) begin
                    bus.n_out    = r_k;
                    bus.fact_out = r_acc;
                    bus.exact    = (r_acc == r_val);
`ifdef INVFACT_REMAINDER_EN
                    bus.rem      = w_rem;
`endif
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_inverse_factorial.sv
// ---------------------------------------------------------------------------
// tb_inverse_factorial
// Directed and randomized checks of inverse_factorial against a factorial
// lookup-table reference model.
// ---------------------------------------------------------------------------
module tb_inverse_factorial;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    int   fact_t [0:9];

    inverse_factorial_if #(.W(16), .KW(4)) bus ();

    inverse_factorial #(.W(16), .KW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Largest n >= 1 with n! <= v, from the factorial table.
    task automatic ref_model(input int v, output int n, output int f);
        n = 0;
        f = 0;
        if (v != 0) begin
            for (int i = 1; i <= 8; i++) begin
                if (fact_t[i] <= v) begin
                    n = i;
                    f = fact_t[i];
                end
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_n"}, 32'(bus.n_out), 0);
        check({tag, "_fact"}, 32'(bus.fact_out), 0);
        check({tag, "_exact"}, 32'(bus.exact), 0);
        check({tag, "_err"}, 32'(bus.err), 0);
`ifdef INVFACT_REMAINDER_EN
        check({tag, "_rem"}, 32'(bus.rem), 0);
`endif
    endtask

    // Called just after E0 (+1). Waits for done, checks latency and results,
    // optionally holds start in DONE, then releases start and checks IDLE.
    task automatic wait_result(input int v, input bit chg, input int hold);
        int n, f, lat, cyc, busy_cnt;
        logic [15:0] f_seen;
        ref_model(v, n, f);
        lat      = (v == 0) ? 1 : n + 1;
        cyc      = 0;
        busy_cnt = 1;
        while (!bus.done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.busy) busy_cnt++;
            if (chg && cyc == 1) bus.xin = 16'd5;
        end
        check("latency", cyc, lat);
        check("busy_cycles", busy_cnt, lat);
        check("done", 32'(bus.done), 1);
        check("n_out", 32'(bus.n_out), n);
        check("fact_out", 32'(bus.fact_out), f);
        check("exact", 32'(bus.exact), (v != 0 && v == f) ? 1 : 0);
        check("err", 32'(bus.err), (v == 0) ? 1 : 0);
`ifdef INVFACT_REMAINDER_EN
        check("rem", 32'(bus.rem), (v == 0) ? 0 : v - f);
`endif
        f_seen = bus.fact_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_done", 32'(bus.done), 1);
            check("hold_fact", 32'(bus.fact_out), 32'(f_seen));
        end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_idle("release");
    endtask

    task automatic run_op(input int v, input bit chg, input int hold);
        @(negedge clk);
        bus.xin   = v[15:0];
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("busy_load", 32'(bus.busy), 1);
        wait_result(v, chg, hold);
    endtask

    initial begin
        int v, sel;
        n_cmp  = 0;
        n_fail = 0;
        fact_t[0] = 1;
        for (int i = 1; i <= 9; i++) fact_t[i] = fact_t[i-1] * i;

        bus.start = 1'b0;
        bus.xin   = '0;
        reset     = 1'b1;
        #1;
        check_idle("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_idle("idle");

        run_op(120, 1'b0, 0);
        run_op(100, 1'b0, 0);
        run_op(0, 1'b0, 0);
        run_op(1, 1'b0, 0);
        run_op(2, 1'b0, 0);
        run_op(65535, 1'b1, 0);
        run_op(40320, 1'b0, 0);
        run_op(40319, 1'b0, 0);

        // Reset mid-STEP with start held high
        @(negedge clk);
        bus.xin   = 16'd65535;
        bus.start = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        check_idle("rst_mid");
        @(posedge clk);
        #1;
        check_idle("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("restart_busy", 32'(bus.busy), 1);
        wait_result(65535, 1'b0, 10);

        for (int it = 0; it < 24; it++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: v = int'($urandom_range(0, 10));
                1: v = int'($urandom_range(0, 1000));
                2: v = fact_t[$urandom_range(1, 8)];
                default: v = int'($urandom_range(0, 65535));
            endcase
            run_op(v, it[0], int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
